// File: rtl/pipe_pkg.sv
// Shared definitions for pipeline stage registers: default widths, the no-op
// encoding and the F/D payload packing (pc high word, instruction low word).
package pipe_pkg;

  localparam logic [31:0] NOP_INSTR      = 32'h2000_0000;
  localparam int          DEFAULT_DATA_W = 64;
  localparam int          DEFAULT_CNT_W  = 16;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fd_payload_t;

  localparam logic [63:0] FD_BUBBLE = {32'h0, NOP_INSTR};

  function automatic fd_payload_t fd_pack(input logic [31:0] pc, input logic [31:0] instr);
    fd_payload_t p;
    p.pc    = pc;
    p.instr = instr;
    return p;
  endfunction

  function automatic logic [31:0] fd_pc(input fd_payload_t p);
    return p.pc;
  endfunction

  function automatic logic [31:0] fd_instr(input fd_payload_t p);
    return p.instr;
  endfunction

endpackage

// File: rtl/pipe_skid_entry.sv
// Single valid+data holding register. clear beats load beats take; take drops
// valid but keeps the payload so the downstream sees a stable value.
module pipe_skid_entry
  import pipe_pkg::*;
#(
  parameter int                DATA_W = DEFAULT_DATA_W,
  parameter logic [DATA_W-1:0] BUBBLE = DATA_W'(FD_BUBBLE)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              load,
  input  logic              take,
  input  logic [DATA_W-1:0] load_data,
  output logic              valid,
  output logic [DATA_W-1:0] data
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= BUBBLE;
    end else if (clear) begin
      valid <= 1'b0;
      data  <= BUBBLE;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
    end else if (take) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pipe_stage_register.sv
// Pipeline stage register with valid/ready handshake, flush-to-bubble and a
// saturating stall counter. Define PIPE_STAGE_SKID_EN for a registered-ready skid entry.
module pipe_stage_register
  import pipe_pkg::*;
#(
  parameter int                DATA_W = DEFAULT_DATA_W,
  parameter logic [DATA_W-1:0] BUBBLE = DATA_W'(FD_BUBBLE),
  parameter int                CNT_W  = DEFAULT_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  stall_count
);

  logic              in_fire;
  logic              out_fire;
  logic              main_valid;
  logic              main_load;
  logic              main_take;
  logic [DATA_W-1:0] main_data;
  logic [DATA_W-1:0] main_load_data;

  assign in_fire   = in_valid & in_ready;
  assign out_fire  = main_valid & out_ready;
  assign out_valid = main_valid;
  assign out_data  = main_data;

`ifdef PIPE_STAGE_SKID_EN
  logic              skid_valid;
  logic              skid_load;
  logic              skid_take;
  logic [DATA_W-1:0] skid_data;

  // Ready comes straight from the skid flop, cutting the out_ready -> in_ready path.
  assign in_ready = ~skid_valid;

  always_comb begin
    main_load      = 1'b0;
    main_load_data = in_data;
    main_take      = 1'b0;
    skid_load      = 1'b0;
    skid_take      = 1'b0;
    if (skid_valid) begin
      // Oldest beat lives in skid once main drains; keep FIFO order.
      main_load      = out_fire;
      main_load_data = skid_data;
      skid_load      = in_fire & out_fire;
      skid_take      = out_fire & ~in_fire;
    end else begin
      main_load = in_fire & (~main_valid | out_fire);
      skid_load = in_fire & main_valid & ~out_fire;
      main_take = out_fire & ~in_fire;
    end
  end

  pipe_skid_entry #(
    .DATA_W (DATA_W),
    .BUBBLE (BUBBLE)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (flush),
    .load      (skid_load),
    .take      (skid_take),
    .load_data (in_data),
    .valid     (skid_valid),
    .data      (skid_data)
  );
`else
  assign in_ready       = ~main_valid | out_ready;
  assign main_load      = in_fire;
  assign main_load_data = in_data;
  assign main_take      = out_fire & ~in_fire;
`endif

  pipe_skid_entry #(
    .DATA_W (DATA_W),
    .BUBBLE (BUBBLE)
  ) u_main (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (flush),
    .load      (main_load),
    .take      (main_take),
    .load_data (main_load_data),
    .valid     (main_valid),
    .data      (main_data)
  );

  // Flush deliberately leaves the counter alone; only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= '0;
    end else if (main_valid && !out_ready && (stall_count != {CNT_W{1'b1}})) begin
      stall_count <= stall_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_stage_register.sv
// Self-checking bench for pipe_stage_register; expectations adapt to PIPE_STAGE_SKID_EN.
module tb_pipe_stage_register;

  localparam logic [63:0] BUB = {32'h0, 32'h2000_0000};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic [63:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [63:0] out_data;
  logic        out_ready;
  logic [15:0] stall_count;

  logic        s_in_valid;
  logic [63:0] s_in_data;
  logic        s_in_ready;
  logic        s_out_valid;
  logic [63:0] s_out_data;
  logic        s_out_ready;
  logic [3:0]  s_stall_count;

  int errors = 0;
  int checks = 0;

  logic [63:0] sb[$];
  logic [63:0] seen[$];
  logic [63:0] src[$];
  int          exp_stall = 0;

  typedef struct {
    logic        iv;
    logic [63:0] id;
    logic        ordy;
    logic        exp_valid;
    logic [63:0] exp_data;
    logic        exp_ready;
  } vec_t;

  vec_t vecs[9];

  always #5 clk = ~clk;

  pipe_stage_register u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_ready   (out_ready),
    .stall_count (stall_count)
  );

  pipe_stage_register #(.CNT_W(4)) u_sat (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (1'b0),
    .in_valid    (s_in_valid),
    .in_data     (s_in_data),
    .in_ready    (s_in_ready),
    .out_valid   (s_out_valid),
    .out_data    (s_out_data),
    .out_ready   (s_out_ready),
    .stall_count (s_stall_count)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock of traffic: drive, check against the queue model, then advance the model.
  task automatic cycle(input logic iv, input logic [63:0] id, input logic ordy,
                       input logic fl, output logic fired);
    logic        ov;
    logic        ir;
    logic        exp_ir;
    logic        mv;
    logic [63:0] od;
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    flush     = fl;
    #1;
    ov = out_valid;
    od = out_data;
    ir = in_ready;
    mv = (sb.size() > 0);
`ifdef PIPE_STAGE_SKID_EN
    exp_ir = (sb.size() < 2);
`else
    exp_ir = !mv || ordy;
`endif
    chk("in_ready", 64'(ir), 64'(exp_ir));
    chk("out_valid", 64'(ov), 64'(mv));
    if (ov && mv) chk("out_data", od, sb[0]);
    chk("stall_count", 64'(stall_count), 64'(exp_stall));
`ifdef PIPE_STAGE_SKID_EN
    out_ready = !ordy;
    #1;
    chk("ready_no_comb_path", 64'(in_ready), 64'(ir));
    out_ready = ordy;
`endif
    fired = iv && ir;
    if (mv && !ordy && exp_stall < 65535) exp_stall++;
    if (fl) begin
      sb.delete();
    end else begin
      if (mv && ordy) begin
        seen.push_back(sb[0]);
        void'(sb.pop_front());
      end
      if (fired) sb.push_back(id);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic f;
    int   n;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    s_in_valid = 1'b0; s_in_data = '0; s_out_ready = 1'b0;

    for (int i = 0; i < 9; i++) begin
      vecs[i].iv        = (i < 8);
      vecs[i].id        = 64'(i + 1);
      vecs[i].ordy      = 1'b1;
      vecs[i].exp_valid = (i > 0);
      vecs[i].exp_data  = (i > 0) ? 64'(i) : BUB;
      vecs[i].exp_ready = 1'b1;
    end

    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Build up a stall, then reset asynchronously in the middle of it.
    cycle(1'b1, 64'h55, 1'b0, 1'b0, f);
    cycle(1'b1, 64'h66, 1'b0, 1'b0, f);
    cycle(1'b1, 64'h66, 1'b0, 1'b0, f);
    in_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("rst_async_valid", 64'(out_valid), 64'(0));
    chk("rst_async_data", out_data, BUB);
    chk("rst_async_stall", 64'(stall_count), 64'(0));
    chk("rst_async_ready", 64'(in_ready), 64'(1));
    sb.delete();
    exp_stall = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hold_valid", 64'(out_valid), 64'(0));
    chk("rst_hold_data", out_data, BUB);
    in_valid = 1'b0;
    rst_n = 1'b1;

    seen.delete();
    for (int i = 0; i < 9; i++) begin
      in_valid  = vecs[i].iv;
      in_data   = vecs[i].id;
      out_ready = vecs[i].ordy;
      flush     = 1'b0;
      #1;
      chk("vec_out_valid", 64'(out_valid), 64'(vecs[i].exp_valid));
      chk("vec_out_data", out_data, vecs[i].exp_data);
      chk("vec_in_ready", 64'(in_ready), 64'(vecs[i].exp_ready));
      cycle(vecs[i].iv, vecs[i].id, vecs[i].ordy, 1'b0, f);
    end
    chk("stream_count", 64'(seen.size()), 64'(8));
    chk("drain_valid", 64'(out_valid), 64'(0));
    chk("drain_keeps_data", out_data, 64'h8);

    // Backpressure: A, B, C offered while downstream is stalled.
    seen.delete();
    src = '{64'hA, 64'hB, 64'hC};
    for (int c = 0; c < 5; c++) begin
      cycle(src.size() > 0, (src.size() > 0) ? src[0] : 64'h0, 1'b0, 1'b0, f);
      if (f) void'(src.pop_front());
    end
    in_valid = 1'b1; in_data = src[0]; out_ready = 1'b0;
    #1;
    chk("bp_in_ready", 64'(in_ready), 64'(0));
    chk("bp_hold_data", out_data, 64'hA);
    chk("bp_stall4", 64'(stall_count), 64'(4));
    n = 0;
    while ((src.size() > 0 || sb.size() > 0) && n < 20) begin
      cycle(src.size() > 0, (src.size() > 0) ? src[0] : 64'h0, 1'b1, 1'b0, f);
      if (f) void'(src.pop_front());
      n++;
    end
    chk("bp_drain_in_time", 64'(n < 20), 64'(1));
    chk("bp_order_len", 64'(seen.size()), 64'(3));
    if (seen.size() == 3) begin
      chk("bp_order0", seen[0], 64'hA);
      chk("bp_order1", seen[1], 64'hB);
      chk("bp_order2", seen[2], 64'hC);
    end

    // Flush with a stalled beat (and a full skid entry when present).
    seen.delete();
    src = '{64'hE, 64'hF};
    for (int c = 0; c < 3; c++) begin
      cycle(src.size() > 0, (src.size() > 0) ? src[0] : 64'h0, 1'b0, 1'b0, f);
      if (f) void'(src.pop_front());
    end
    src.delete();
    cycle(1'b1, 64'hD, 1'b0, 1'b1, f);
    chk("flush_valid", 64'(out_valid), 64'(0));
    chk("flush_data", out_data, BUB);
    chk("flush_keeps_stall", 64'(stall_count), 64'(exp_stall));
    chk("flush_stall_nonzero", 64'(stall_count > 0), 64'(1));
    cycle(1'b1, 64'hD, 1'b1, 1'b1, f);
    chk("flush_accepts_beat", 64'(f), 64'(1));
    cycle(1'b1, 64'h9, 1'b1, 1'b0, f);
    cycle(1'b0, 64'h0, 1'b1, 1'b0, f);
    chk("flush_after_len", 64'(seen.size()), 64'(1));
    if (seen.size() == 1) chk("flush_no_d", seen[0], 64'h9);

    // Randomised handshake traffic, occasional flush.
    for (int c = 0; c < 400; c++) begin
      cycle(1'($urandom_range(1, 0)), {$urandom, $urandom}, 1'($urandom_range(1, 0)),
            ($urandom_range(31, 0) == 0), f);
    end
    n = 0;
    while (sb.size() > 0 && n < 10) begin
      cycle(1'b0, 64'h0, 1'b1, 1'b0, f);
      n++;
    end
    chk("rand_drained", 64'(sb.size()), 64'(0));

    // Saturation on the 4-bit counter instance.
    s_out_ready = 1'b0; s_in_valid = 1'b1; s_in_data = 64'h77;
    @(posedge clk);
    #1;
    s_in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("sat_count10", 64'(s_stall_count), 64'(10));
    repeat (5) @(posedge clk);
    #1;
    chk("sat_count15", 64'(s_stall_count), 64'(15));
    repeat (5) @(posedge clk);
    #1;
    chk("sat_stays15", 64'(s_stall_count), 64'(15));
    chk("sat_hold_data", s_out_data, 64'h77);
    chk("sat_hold_valid", 64'(s_out_valid), 64'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_stage_register.md
# pipe_stage_register

Parametrised pipeline stage register with a valid/ready handshake, flush-to-bubble and saturating stall accounting. It generalises the fetch/decode stage register: any payload width, bubble value chosen per instance, explicit valid bit instead of relying on a no-op encoding, and backpressure via ready. Every inter-stage boundary of the CPU (F/D, D/X, X/M, M/W) instantiates one.

## Interface
- DATA_W, 64: payload width (F/D: PC 32 + instruction 32).
- BUBBLE, {32'h0, 32'h20000000}: payload value loaded on reset and flush (no-op `addi $0,$0,0` in the low word).
- CNT_W, 16: stall counter width.
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous kill of all held beats.
- in_valid  in  1  upstream beat present.
- in_data  in  DATA_W  upstream payload.
- in_ready  out  1  stage accepts a beat this cycle.
- out_valid  out  1  stage holds a valid beat.
- out_data  out  DATA_W  held payload.
- out_ready  in  1  downstream accepts this cycle.
- stall_count  out  CNT_W  saturating count of stalled cycles.

## Operation
- in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Base mode, one entry: in_ready = ~out_valid | out_ready (combinational from out_ready).
- On in_fire: out_data <= in_data, out_valid <= 1. On out_fire without in_fire: out_valid <= 0; out_data keeps its value.
- out_valid=1 & out_ready=0: out_valid and out_data hold. This replaces the old load_enable stall.
- Flush has priority over all loads. Next cycle: out_valid=0, out_data=BUBBLE, skid entry emptied. A beat that fires on the input during a flush cycle is consumed and dropped. in_ready is not gated by flush.
- stall_count increments on every cycle with out_valid & ~out_ready. It saturates at 2^CNT_W-1 and is not cleared by flush.
- Payload is opaque. No arithmetic is performed on it.

## Timing
- Reset (asynchronous assert, synchronous-safe release): out_valid=0, out_data=BUBBLE, stall_count=0, skid empty. In base mode in_ready=1 during reset. In skid mode in_ready=1 after reset.
- Latency is 1 cycle from in_fire to out_valid in both modes.
- Throughput is 1 beat per cycle with out_ready held high.
- Asserting rst_n mid-stall discards the held beat immediately. Outputs take their reset values without waiting for a clock edge.
- Flush and reset produce identical outputs, except stall_count, which only reset clears.

## Configuration
- PIPE_STAGE_SKID_EN defined: adds a second (skid) entry. in_ready = ~skid_valid, driven from a flop, with no combinational path from out_ready.
  - Beat arrives while main is full and out_fire=0: it goes to skid.
  - out_fire while skid is full: skid moves to main, and skid refills if in_fire.
  - Ordering is strictly FIFO.
- PIPE_STAGE_SKID_EN undefined: single entry, combinational ready as above.

## Structure
- Shared package pipe_pkg holds:
  - NOP_INSTR = 32'h20000000.
  - Default DATA_W and CNT_W.
  - The F/D payload packing (pc in the high word, instruction in the low word).
- One sub-module, pipe_skid_entry: a single valid+data holding register with load and clear. It is instantiated once for main and, under PIPE_STAGE_SKID_EN, once for skid.
- stall_count logic stays in the top module.

## Test plan
- Reset: hold rst_n=0 for 3 cycles mid-traffic -> out_valid=0, out_data=BUBBLE and stall_count=0 asynchronously. Then stream 0x1..0x8 with out_ready=1 -> each value appears 1 cycle later, back-to-back.
- Backpressure: send 0xA, 0xB, 0xC with out_ready=0 for 4 cycles.
  - Base mode: out_data holds 0xA and in_ready=0.
  - Skid mode: 0xB is captured in skid and in_ready=0 from the next cycle.
  - In both modes stall_count=4, then order is 0xA, 0xB, 0xC after release.
- Flush: assert flush with a valid stall and skid full, plus in_valid=1 carrying 0xD -> next cycle out_valid=0, out_data=BUBBLE, 0xD never appears, stall_count unchanged.
- Saturation: CNT_W=4 with out_valid=1 and out_ready=0 for 20 cycles -> stall_count=15 and stays 15.
- Randomised ready/valid with scoreboard in both macro settings -> no loss, no duplication, in-order delivery. With PIPE_STAGE_SKID_EN, in_ready shows no same-cycle dependence on out_ready.
